// File: rtl/aes_ofb_stream_ctrl.sv
// AES-128 OFB stream controller: turns an upstream block stream into a
// keystream-XORed downstream stream using an external AES block engine.
// Encryption and decryption share this one path.
// Optional feature: define OFB_PREFETCH_EN to compute the next keystream
// block ahead of time, so an accepted block leaves on the following cycle.
module aes_ofb_stream_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_din,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ARMED, GEN, OUT} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_r;
  logic [127:0] ks;
  logic         ld_pend;
  logic         done_ok;

  assign core_key = key_r;
  assign core_din = ks;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef OFB_PREFETCH_EN
  logic ks_valid;
  logic req_out;
  logic accept;

  assign accept  = (state == ARMED) && ks_valid && s_valid;
  assign done_ok = core_done && req_out && !ld_pend;

  // Next state and handshake outputs; GEN is never entered with prefetch
  always_comb begin
    state_nxt = state;
    s_ready   = (state == ARMED) && ks_valid;
    m_valid   = (state == OUT);
    busy      = (state != IDLE);
    core_ld   = ld_pend;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED:   if (accept) state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = m_last ? IDLE : ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: session load, keystream refill from the engine, output XOR
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r    <= '0;
      ks       <= '0;
      m_data   <= '0;
      m_last   <= 1'b0;
      ld_pend  <= 1'b0;
      ks_valid <= 1'b0;
      req_out  <= 1'b0;
    end else begin
      ld_pend <= 1'b0;
      if (ld_pend) req_out <= 1'b1;
      if (state == IDLE && start) begin
        key_r    <= key;
        ks       <= iv;
        ks_valid <= 1'b0;
        ld_pend  <= 1'b1;
      end
      if (done_ok) begin
        ks       <= core_dout;
        ks_valid <= 1'b1;
        req_out  <= 1'b0;
      end
      if (accept) begin
        m_data   <= s_data ^ ks;
        m_last   <= s_last;
        ks_valid <= 1'b0;
        ld_pend  <= !s_last;
      end
    end
  end
`else
  logic [127:0] data_r;
  logic         last_r;

  assign done_ok = core_done && (state == GEN) && !ld_pend;

  // Next state and handshake outputs; core_ld only in the first GEN cycle
  always_comb begin
    state_nxt = state;
    s_ready   = (state == ARMED);
    m_valid   = (state == OUT);
    busy      = (state != IDLE);
    core_ld   = ld_pend;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED:   if (s_valid) state_nxt = GEN;
      GEN:     if (done_ok) state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = m_last ? IDLE : ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: session load, block latch, keystream update and output XOR
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r   <= '0;
      ks      <= '0;
      data_r  <= '0;
      last_r  <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      ld_pend <= 1'b0;
    end else begin
      ld_pend <= 1'b0;
      if (state == IDLE && start) begin
        key_r <= key;
        ks    <= iv;
      end
      if (state == ARMED && s_valid) begin
        data_r  <= s_data;
        last_r  <= s_last;
        ld_pend <= 1'b1;
      end
      if (done_ok) begin
        ks     <= core_dout;
        m_data <= data_r ^ core_dout;
        m_last <= last_r;
      end
    end
  end
`endif

endmodule
